delay_credit_buffer: RTL and testbench

- Output stage directly downstream of the fixed-latency delay chain (NUM_DELAY register stages, no stall capability).
- Gates issue into the chain with credits, so every word leaving the chain has a guaranteed slot.
- Tracks validity of in-flight words with its own shift register.
- Buffers chain output in a FIFO and presents it on a valid/ready master interface, so a stalling consumer can sit behind a non-stallable pipeline.

---
 rtl/dcb_pkg.sv | 20 ++
 rtl/dcb_sync_fifo.sv | 84 ++++++++
 rtl/delay_credit_buffer.sv | 129 ++++++++++++
 tb/tb_delay_credit_buffer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcb_pkg.sv
// Shared definitions for the delay credit buffer.
//
// Contents:
//   DcbDefaultN / DcbDefaultNumDelay / DcbDefaultDepth - default data width, chain latency and
//       FIFO depth, reused wherever the upstream delay chain is instantiated.
//   dcb_cnt_width()                                    - width of an occupancy counter that must
//       hold every value from 0 up to and including DEPTH.

package dcb_pkg;

    localparam int unsigned DcbDefaultN        = 32;
    localparam int unsigned DcbDefaultNumDelay = 5;
    localparam int unsigned DcbDefaultDepth    = 8;

    // Counters hold 0..depth inclusive, so size them for depth+1 distinct values.
    function automatic int unsigned dcb_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dcb_sync_fifo.sv
// Register-array synchronous FIFO used as the landing buffer behind the delay chain.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset (pointers and count clear)
//   wr_en    in   write wr_data at the tail this cycle (caller guarantees space)
//   wr_data  in   N-bit word to write
//   rd_en    in   drop the head word this cycle (ignored while empty)
//   rd_data  out  head word, combinational read of the array
//   count    out  number of stored words, 0..DEPTH
//   empty    out  count == 0
//
// Pointers wrap by explicit compare, so DEPTH need not be a power of two.

module dcb_sync_fifo
    import dcb_pkg::*;
#(
    parameter int unsigned N     = DcbDefaultN,
    parameter int unsigned DEPTH = DcbDefaultDepth,
    localparam int unsigned CntW = dcb_cnt_width(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [N-1:0]    wr_data,
    input  logic            rd_en,
    output logic [N-1:0]    rd_data,
    output logic [CntW-1:0] count,
    output logic            empty
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);

    logic [N-1:0]    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_rd;

    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_rd   = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + PtrW'(1);
        end

        unique case ({wr_en, do_rd})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/delay_credit_buffer.sv
// Output stage behind a fixed-latency, non-stallable delay chain.
//
// Issue into the chain is gated by credits so every word that leaves the chain already owns a
// FIFO slot. A private shift register tracks which chain stages hold real words; arriving words
// land in a FIFO that is presented on a valid/ready master port.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   issue_valid  in   producer offers a word to the chain this cycle
//   issue_ready  out  credit available (from registered state only)
//   pipe_data    in   N-bit output of the delay chain
//   m_valid      out  FIFO not empty
//   m_ready      in   consumer takes the head word
//   m_data       out  head word of the FIFO
//   ovf_err      out  sticky overflow flag, present only when DELAY_CREDIT_BUFFER_OVF_CHECK_EN
//                     is defined; flags an arrival into a full FIFO (chain latency mismatch)
//
// Build option: `define DELAY_CREDIT_BUFFER_OVF_CHECK_EN adds ovf_err and suppresses writes that
// would overflow. Without it the port and the check logic are absent.

module delay_credit_buffer
    import dcb_pkg::*;
#(
    parameter int unsigned N         = DcbDefaultN,
    parameter int unsigned NUM_DELAY = DcbDefaultNumDelay,
    parameter int unsigned DEPTH     = DcbDefaultDepth
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue_valid,
    output logic         issue_ready,
    input  logic [N-1:0] pipe_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_data
`ifdef DELAY_CREDIT_BUFFER_OVF_CHECK_EN
    ,
    output logic         ovf_err
`endif
);

    localparam int unsigned CntW = dcb_cnt_width(DEPTH);
    // One extra bit so inflight + count cannot wrap before the compare.
    localparam int unsigned SumW = CntW + 1;

    logic [NUM_DELAY-1:0] vld_sr_q, vld_sr_d;
    logic [CntW-1:0]      inflight_q, inflight_d;
    logic [CntW-1:0]      count;
    logic                 empty;
    logic                 issue_fire;
    logic                 arrive;
    logic                 pop;
    logic                 fifo_wr;
    logic [SumW-1:0]      used;

    assign issue_fire = issue_valid && issue_ready;
    assign arrive     = vld_sr_q[NUM_DELAY-1];
    assign m_valid    = !empty;
    assign pop        = m_valid && m_ready;

    // Slots already promised: words still in the chain plus words sitting in the FIFO.
    assign used        = SumW'(inflight_q) + SumW'(count);
    assign issue_ready = (used < SumW'(DEPTH));

    always_comb begin
        vld_sr_d    = vld_sr_q;
        vld_sr_d[0] = issue_fire;
        for (int unsigned k = 1; k < NUM_DELAY; k++) begin
            vld_sr_d[k] = vld_sr_q[k-1];
        end
    end

    always_comb begin
        unique case ({issue_fire, arrive})
            2'b10:   inflight_d = inflight_q + CntW'(1);
            2'b01:   inflight_d = inflight_q - CntW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_sr_q   <= '0;
            inflight_q <= '0;
        end else begin
            vld_sr_q   <= vld_sr_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef DELAY_CREDIT_BUFFER_OVF_CHECK_EN
    logic full;
    logic ovf_hit;
    logic ovf_q, ovf_d;

    assign full    = (count == CntW'(DEPTH));
    // A pop in the same cycle frees the slot, so only arrive-into-full-without-pop is fatal.
    assign ovf_hit = arrive && full && !pop;
    assign fifo_wr = arrive && !ovf_hit;
    assign ovf_d   = ovf_q || ovf_hit;
    assign ovf_err = ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`else
    assign fifo_wr = arrive;
`endif

    dcb_sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (pipe_data),
        .rd_en   (pop),
        .rd_data (m_data),
        .count   (count),
        .empty   (empty)
    );

endmodule

// File: tb/tb_delay_credit_buffer.sv
// Bench for delay_credit_buffer: a model delay chain feeds the DUT, and a queue-based reference
// model predicts issue_ready, m_valid and m_data from the external rules (outstanding words vs
// DEPTH, fixed issue-to-output latency, in-order delivery).

module tb_delay_credit_buffer;
    import dcb_pkg::*;

    localparam int unsigned N     = 32;
    localparam int unsigned ND    = 5;
    localparam int unsigned DEPTH = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         issue_valid = 1'b0;
    logic         issue_ready;
    logic [N-1:0] pipe_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [N-1:0] m_data;
    logic [N-1:0] issue_word = '0;
`ifdef DELAY_CREDIT_BUFFER_OVF_CHECK_EN
    logic         ovf_err;
`endif

    always #5 clk = ~clk;

    // Model of the upstream chain: carries the word on fire cycles, zero otherwise.
    logic [N-1:0] chain [ND] = '{default: '0};
    always @(posedge clk) begin
        chain[0] <= (issue_valid && issue_ready) ? issue_word : '0;
        for (int k = 1; k < ND; k++) chain[k] <= chain[k-1];
    end
    assign pipe_data = chain[ND-1];

    delay_credit_buffer #(
        .N         (N),
        .NUM_DELAY (ND),
        .DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .pipe_data   (pipe_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data)
`ifdef DELAY_CREDIT_BUFFER_OVF_CHECK_EN
        ,
        .ovf_err     (ovf_err)
`endif
    );

`ifdef DELAY_CREDIT_BUFFER_OVF_CHECK_EN
    // Mismatched instance: DUT believes latency 4, real chain is 5.
    logic         iv2 = 1'b0;
    logic [N-1:0] w2 = '0;
    logic         ir2, mv2, ovf2;
    logic [N-1:0] md2, pd2;
    logic [N-1:0] chain2 [ND] = '{default: '0};
    always @(posedge clk) begin
        chain2[0] <= iv2 ? w2 : '0;
        for (int k = 1; k < ND; k++) chain2[k] <= chain2[k-1];
    end
    assign pd2 = chain2[ND-1];

    delay_credit_buffer #(
        .N         (N),
        .NUM_DELAY (4),
        .DEPTH     (DEPTH)
    ) dut2 (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (iv2),
        .issue_ready (ir2),
        .pipe_data   (pd2),
        .m_valid     (mv2),
        .m_ready     (1'b0),
        .m_data      (md2),
        .ovf_err     (ovf2)
    );
`endif

    typedef struct {
        logic [N-1:0] data;
        int           t;
    } ent_t;

    ent_t q[$];
    int   cyc = 0;
    int   outstanding = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   seen_valid = 0;
    int   accepted = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the negedge, advance the model.
    task automatic step(input logic iv, input logic mr, input logic [N-1:0] w);
        logic exp_rdy, exp_mv, fire, pop;
        ent_t e;
        issue_valid = iv;
        m_ready     = mr;
        issue_word  = w;
        @(negedge clk);
        exp_rdy = (outstanding < int'(DEPTH));
        exp_mv  = (q.size() > 0) && (q[0].t + int'(ND) + 1 <= cyc);
        chk("issue_ready", 64'(issue_ready), 64'(exp_rdy));
        chk("m_valid", 64'(m_valid), 64'(exp_mv));
        if (exp_mv) chk("m_data", 64'(m_data), 64'(q[0].data));
`ifdef DELAY_CREDIT_BUFFER_OVF_CHECK_EN
        chk("ovf_err_quiet", 64'(ovf_err), 64'd0);
`endif
        if (m_valid === 1'b1) seen_valid++;
        if (iv && issue_ready === 1'b1) accepted++;
        fire = iv && exp_rdy;
        pop  = exp_mv && mr;
        @(posedge clk);
        if (pop) begin
            void'(q.pop_front());
            outstanding--;
        end
        if (fire) begin
            e.data = w;
            e.t    = cyc;
            q.push_back(e);
            outstanding++;
        end
        cyc++;
        #1;
    endtask

    int pat [6] = '{1, 0, 1, 0, 0, 1};

    initial begin
        // Reset state
        #12;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("rst_inflight", 64'(dut.inflight_q), 64'd0);
        #11;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single word issued in cycle 10, visible only in cycle 16
        seen_valid = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 32'hDEADBEEF);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, '0);
        chk("single_valid_cycles", 64'(seen_valid), 64'd1);
        chk("single_inflight", 64'(dut.inflight_q), 64'd0);

        // Streaming at full rate
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, $urandom());
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0);

        // Backpressure: fill to DEPTH, then drain
        accepted = 0;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, $urandom());
        chk("bp_accepted", 64'(accepted), 64'(DEPTH));
        chk("bp_count", 64'(dut.count), 64'(DEPTH));
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, '0);

        // Sparse issue with random consumer stalls
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 6; i++) begin
                step(pat[i] != 0, 1'($urandom_range(0, 1)), $urandom());
            end
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, '0);

        // Reset with 2 words buffered and 3 in flight
        step(1'b1, 1'b0, $urandom());
        step(1'b1, 1'b0, $urandom());
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, $urandom());
        step(1'b1, 1'b0, $urandom());
        step(1'b1, 1'b0, $urandom());
        chk("pre_rst_count", 64'(dut.count), 64'd2);
        issue_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_issue_ready", 64'(issue_ready), 64'd1);
        q.delete();
        outstanding = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, '0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, $urandom());
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, '0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), $urandom());
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, '0);

`ifdef DELAY_CREDIT_BUFFER_OVF_CHECK_EN
        // Over-issue into a DUT whose latency setting is one short of the real chain
        chk("ovf_initial", 64'(ovf2), 64'd0);
        force dut2.issue_fire = iv2;
        for (int i = 0; i < 12; i++) begin
            iv2 = 1'b1;
            w2  = N'(i + 1);
            @(posedge clk);
            #1;
        end
        iv2 = 1'b0;
        for (int i = 0; i < 8; i++) @(posedge clk);
        #1;
        chk("ovf_set", 64'(ovf2), 64'd1);
        chk("ovf_m_valid", 64'(mv2), 64'd1);
        // First landed word was sampled a cycle early from the idle chain
        chk("ovf_head", 64'(md2), 64'd0);
        release dut2.issue_fire;
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        chk("ovf_sticky", 64'(ovf2), 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
